// File: rtl/pipe_pkg.sv
// Shared types for the generic inter-stage pipeline register: occupancy state
// encoding and the per-stage payload structs that callers pack into PAYLOAD_W.
package pipe_pkg;

   localparam int OCC_W = 2;

   // Encoding doubles as the occupancy count driven on occupancy_o.
   typedef enum logic [1:0] {
      PR_EMPTY = 2'd0,
      PR_ONE   = 2'd1,
      PR_TWO   = 2'd2
   } pr_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } if_id_payload_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic        rf_we;
      logic [1:0]  wd_sel;
      logic        wr;
      logic [3:0]  alu_op;
   } id_ex_payload_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] alu_result;
      logic [31:0] rs2_val;
      logic [4:0]  rd;
      logic        rf_we;
      logic [1:0]  wd_sel;
      logic        wr;
   } ex_mem_payload_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] alu_result;
      logic [31:0] rd_data;
      logic [4:0]  rd;
      logic        rf_we;
      logic [1:0]  wd_sel;
   } mem_wb_payload_t;

endpackage

// File: rtl/pr_slot.sv
// One valid+payload register. Clear wins over load for the valid bit; the
// payload only changes on load so its flops can be clock-gated.
module pr_slot #(
   parameter int                   PAYLOAD_W = 128,
   parameter logic [PAYLOAD_W-1:0] RST_VAL   = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_load,
   input  logic                 i_clr,
   input  logic [PAYLOAD_W-1:0] i_d,
   output logic                 o_valid,
   output logic [PAYLOAD_W-1:0] o_q
);

   logic                 r_valid;
   logic [PAYLOAD_W-1:0] r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_q     <= RST_VAL;
      end else begin
         if (i_clr) begin
            r_valid <= 1'b0;
         end else if (i_load) begin
            r_valid <= 1'b1;
         end
         if (i_load) begin
            r_q <= i_d;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_q     = r_q;

endmodule

// File: rtl/pr_stage_skid.sv
// Generic pipeline-stage register with valid/ready handshake, flush and an
// optional two-entry skid buffer that makes up_ready_o a pure register output.
module pr_stage_skid
   import pipe_pkg::*;
#(
   parameter int                   PAYLOAD_W = 128,
   parameter logic [PAYLOAD_W-1:0] RST_VAL   = '0,
   parameter bit                   SKID_EN   = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush_i,
   input  logic                 up_valid_i,
   output logic                 up_ready_o,
   input  logic [PAYLOAD_W-1:0] up_payload_i,
   output logic                 dn_valid_o,
   input  logic                 dn_ready_i,
   output logic [PAYLOAD_W-1:0] dn_payload_o,
   output logic [OCC_W-1:0]     occupancy_o
);

   logic w_up_xfer;
   logic w_dn_xfer;

   assign w_up_xfer = up_valid_i & up_ready_o;
   assign w_dn_xfer = dn_valid_o & dn_ready_i;

   generate
      if (SKID_EN) begin : g_skid
         pr_state_e            r_state;
         logic                 r_up_ready;
         logic                 w_main_load, w_main_clr, w_main_valid;
         logic                 w_skid_load, w_skid_clr, w_skid_valid;
         logic [PAYLOAD_W-1:0] w_main_d, w_main_q, w_skid_q;

         // Main takes upstream data when it is empty or draining this cycle;
         // otherwise it refills from skid. Flush suppresses every load.
         assign w_main_load = !flush_i &
                              (((r_state == PR_EMPTY) & w_up_xfer) |
                               ((r_state == PR_ONE) & w_up_xfer & dn_ready_i) |
                               ((r_state == PR_TWO) & w_dn_xfer));
         assign w_main_d    = (r_state == PR_TWO) ? w_skid_q : up_payload_i;
         assign w_main_clr  = flush_i | ((r_state == PR_ONE) & w_dn_xfer & !w_up_xfer);
         assign w_skid_load = !flush_i & (r_state == PR_ONE) & w_up_xfer & !dn_ready_i;
         assign w_skid_clr  = flush_i | ((r_state == PR_TWO) & w_dn_xfer);

         pr_slot #(.PAYLOAD_W(PAYLOAD_W), .RST_VAL(RST_VAL)) u_main (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_main_load),
            .i_clr   (w_main_clr),
            .i_d     (w_main_d),
            .o_valid (w_main_valid),
            .o_q     (w_main_q)
         );

         pr_slot #(.PAYLOAD_W(PAYLOAD_W), .RST_VAL(RST_VAL)) u_skid (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_skid_load),
            .i_clr   (w_skid_clr),
            .i_d     (up_payload_i),
            .o_valid (w_skid_valid),
            .o_q     (w_skid_q)
         );

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_state    <= PR_EMPTY;
               r_up_ready <= 1'b0;
            end else if (flush_i) begin
               r_state    <= PR_EMPTY;
               r_up_ready <= 1'b1;
            end else begin
               case (r_state)
                  PR_EMPTY: begin
                     r_up_ready <= 1'b1;
                     if (w_up_xfer) r_state <= PR_ONE;
                  end
                  PR_ONE: begin
                     if (w_up_xfer && !dn_ready_i) begin
                        r_state    <= PR_TWO;
                        r_up_ready <= 1'b0;
                     end else begin
                        r_up_ready <= 1'b1;
                        if (!w_up_xfer && w_dn_xfer) r_state <= PR_EMPTY;
                     end
                  end
                  PR_TWO: begin
                     r_up_ready <= w_dn_xfer;
                     if (w_dn_xfer) r_state <= PR_ONE;
                  end
                  default: begin
                     r_state    <= PR_EMPTY;
                     r_up_ready <= 1'b1;
                  end
               endcase
            end
         end

         a_skid_consistent: assert property (@(posedge clk) disable iff (!rst_n)
            w_skid_valid == (r_state == PR_TWO));

         assign up_ready_o   = r_up_ready;
         assign dn_valid_o   = w_main_valid;
         assign dn_payload_o = w_main_q;
         assign occupancy_o  = r_state;
      end else begin : g_single
         logic                 r_live;
         logic                 w_main_load, w_main_clr, w_main_valid;
         logic [PAYLOAD_W-1:0] w_main_q;

         // Holds ready low while in reset and until the first edge after it.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_live <= 1'b0;
            else        r_live <= 1'b1;
         end

         assign w_main_load = !flush_i & w_up_xfer;
         assign w_main_clr  = flush_i | (w_dn_xfer & !w_up_xfer);

         pr_slot #(.PAYLOAD_W(PAYLOAD_W), .RST_VAL(RST_VAL)) u_main (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_main_load),
            .i_clr   (w_main_clr),
            .i_d     (up_payload_i),
            .o_valid (w_main_valid),
            .o_q     (w_main_q)
         );

         assign up_ready_o   = r_live & (!w_main_valid | dn_ready_i);
         assign dn_valid_o   = w_main_valid;
         assign dn_payload_o = w_main_q;
         assign occupancy_o  = {{(OCC_W-1){1'b0}}, w_main_valid};
      end
   endgenerate

   a_up_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (up_valid_i && !up_ready_o) |=> (!up_valid_i || $stable(up_payload_i)));

endmodule

// File: tb/tb_pr_stage_skid.sv
// Bench for pr_stage_skid: skid and single-register variants driven in lockstep
// and compared every cycle against queue-based reference models.
module tb_pr_stage_skid;
   localparam int              W    = 32;
   localparam logic [W-1:0]    RST1 = 32'hDEAD_BEEF;
   localparam logic [W-1:0]    RST0 = 32'h0000_0000;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         flush_i = 1'b0;
   logic         up_valid_i = 1'b0;
   logic         dn_ready_i = 1'b0;
   logic [W-1:0] up_payload_i = '0;

   logic         up_ready1, dn_valid1, up_ready0, dn_valid0;
   logic [W-1:0] pay1, pay0;
   logic [1:0]   occ1, occ0;

   pr_stage_skid #(.PAYLOAD_W(W), .RST_VAL(RST1), .SKID_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .up_valid_i(up_valid_i), .up_ready_o(up_ready1), .up_payload_i(up_payload_i),
      .dn_valid_o(dn_valid1), .dn_ready_i(dn_ready_i), .dn_payload_o(pay1),
      .occupancy_o(occ1));

   pr_stage_skid #(.PAYLOAD_W(W), .RST_VAL(RST0), .SKID_EN(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .up_valid_i(up_valid_i), .up_ready_o(up_ready0), .up_payload_i(up_payload_i),
      .dn_valid_o(dn_valid0), .dn_ready_i(dn_ready_i), .dn_payload_o(pay0),
      .occupancy_o(occ0));

   always #5 clk = ~clk;

   int           n_vec = 0;
   int           n_err = 0;
   logic [W-1:0] q1[$];
   logic [W-1:0] q0[$];
   logic         m_rdy1 = 1'b0;
   logic         m_live0 = 1'b0;
   logic         hold_req = 1'b0;
   logic [W-1:0] last_up = '0;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic m_rdy0();
      return m_live0 && (q0.size() == 0 || dn_ready_i);
   endfunction

   task automatic post_check();
      chk("dn_valid1", W'(dn_valid1), W'(q1.size() != 0));
      if (q1.size() != 0) chk("dn_payload1", pay1, q1[0]);
      chk("occupancy1", W'(occ1), W'(q1.size()));
      chk("up_ready1", W'(up_ready1), W'(m_rdy1));
      chk("dn_valid0", W'(dn_valid0), W'(q0.size() != 0));
      if (q0.size() != 0) chk("dn_payload0", pay0, q0[0]);
      chk("occupancy0", W'(occ0), W'(q0.size()));
      chk("up_ready0", W'(up_ready0), W'(m_rdy0()));
   endtask

   // One clock: drive at negedge, check combinational ready, advance models at posedge.
   task automatic cyc(input logic uv, input logic [W-1:0] up, input logic dr,
                      input logic fl, input logic rs);
      logic x1, x0, d1, d0;
      @(negedge clk);
      if (hold_req && uv) up = last_up;
      rst_n = rs; up_valid_i = uv; up_payload_i = up; dn_ready_i = dr; flush_i = fl;
      #1;
      chk("up_ready0_comb", W'(up_ready0), W'(m_rdy0()));
      x1 = uv && m_rdy1;
      x0 = uv && m_rdy0();
      d1 = (q1.size() != 0) && dr;
      d0 = (q0.size() != 0) && dr;
      hold_req = rs && uv && (!m_rdy1 || !m_rdy0());
      last_up  = up;
      @(posedge clk);
      if (!rs) begin
         q1.delete(); q0.delete(); m_rdy1 = 1'b0; m_live0 = 1'b0;
      end else begin
         if (fl) begin
            q1.delete(); q0.delete();
         end else begin
            if (d1) void'(q1.pop_front());
            if (x1) q1.push_back(up);
            if (d0) void'(q0.pop_front());
            if (x0) q0.push_back(up);
         end
         m_rdy1  = (q1.size() != 2);
         m_live0 = 1'b1;
      end
      #1;
      post_check();
   endtask

   initial begin
      // Reset for three cycles, then release.
      repeat (3) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("rst_payload1", pay1, RST1);
      chk("rst_payload0", pay0, RST0);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);

      // Single push and consume.
      cyc(1'b1, 32'h0000_1234, 1'b1, 1'b0, 1'b1);
      chk("push_payload", pay1, 32'h0000_1234);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
      chk("push_drained_occ", W'(occ1), W'(0));

      // Stall fill to TWO, hold, then drain in order.
      cyc(1'b1, 32'hA, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 32'hB, 1'b0, 1'b0, 1'b1);
      chk("stall_ready_low", W'(up_ready1), W'(0));
      repeat (5) begin
         cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
         chk("stall_hold_A", pay1, 32'hA);
      end
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
      chk("drain_B", pay1, 32'hB);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);

      // Streaming back-to-back.
      for (int i = 0; i < 100; i++) cyc(1'b1, 32'h100 + i, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);

      // Flush colliding with an upstream push while in TWO.
      cyc(1'b1, 32'hC, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 32'hD, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 32'hE, 1'b0, 1'b1, 1'b1);
      chk("flush_valid", W'(dn_valid1), W'(0));
      repeat (3) cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);

      // Asynchronous reset between edges while in TWO.
      cyc(1'b1, 32'h11, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 32'h22, 1'b0, 1'b0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid1", W'(dn_valid1), W'(0));
      chk("async_payload1", pay1, RST1);
      chk("async_occ1", W'(occ1), W'(0));
      chk("async_ready1", W'(up_ready1), W'(0));
      chk("async_valid0", W'(dn_valid0), W'(0));
      chk("async_payload0", pay0, RST0);
      q1.delete(); q0.delete(); m_rdy1 = 1'b0; m_live0 = 1'b0; hold_req = 1'b0;
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

      // Single-register variant: same-cycle ready and push/pop overlap.
      cyc(1'b1, 32'h55, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("single_ready_stall", W'(up_ready0), W'(0));
      cyc(1'b1, 32'h66, 1'b1, 1'b0, 1'b1);
      chk("single_pushpop_occ", W'(occ0), W'(1));
      chk("single_pushpop_pay", pay0, 32'h66);

      // Randomized traffic with occasional flushes.
      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 9) < 7),
             1'($urandom_range(0, 19) == 0), 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pr_stage_skid.md
Name: pr_stage_skid

Overview:
- Generic, parametrised pipeline-stage register and the successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque packed payload plus a valid bit over a valid/ready handshake, so a downstream stall no longer corrupts in-flight data.
- Adds flush, an optional two-entry skid buffer for registered ready, and an occupancy output for hazard/debug logic.

Parameters:
- PAYLOAD_W, 128: payload width in bits; any value >= 1.
- RST_VAL, '0: payload register value on reset; width PAYLOAD_W.
- SKID_EN, 1: 1 = two-entry skid buffer with registered up_ready_o; 0 = single register with combinational ready.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  kill all held entries (branch mispredict or trap).
- up_valid_i  in  1  upstream stage presents an entry.
- up_ready_o  out  1  stage can accept this cycle.
- up_payload_i  in  PAYLOAD_W  upstream payload (pc, rf_we, wd_sel, wr, alu_result, ...).
- dn_valid_o  out  1  downstream entry valid (replaces the instr_valid field).
- dn_ready_i  in  1  downstream stage consumes; low = stall.
- dn_payload_o  out  PAYLOAD_W  downstream payload, driven from a register.
- occupancy_o  out  2  number of held entries: 0, 1 or 2.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low, on rst_n.
- Reset values: dn_valid_o=0, dn_payload_o=RST_VAL, skid payload=RST_VAL, skid valid=0, occupancy_o=0.
  - up_ready_o=1 in the cycle after reset deasserts. It is 0 while rst_n is low.
- Transfer rules: upstream transfer = up_valid_i & up_ready_o. Downstream transfer = dn_valid_o & dn_ready_i.
- Latency: 1 cycle. An entry accepted at edge N appears on dn_* after edge N. Strict FIFO order; no reordering or duplication.
- SKID_EN=1: states EMPTY, ONE (main full), TWO (main + skid full); occupancy_o encodes the state.
  - EMPTY: on upstream transfer, load main -> ONE.
  - ONE, up only: if dn_ready_i, main <= up, stay ONE. Otherwise skid <= up -> TWO.
  - ONE, dn only: -> EMPTY.
  - ONE, neither: hold.
  - TWO: up_ready_o=0. On downstream transfer, main <= skid -> ONE. Otherwise hold.
  - up_ready_o is registered: it equals !(state==TWO) and depends on no same-cycle input.
- SKID_EN=0: single main register.
  - up_ready_o = !dn_valid_o | dn_ready_i (combinational).
  - occupancy_o is 0 or 1.
- Flush:
  - flush_i=1 clears both valids at the next edge -> EMPTY, occupancy 0.
  - Flush overrides a simultaneous upstream transfer: that entry is dropped.
  - Payload registers may keep stale data. Only dn_valid_o is authoritative, and dn_payload_o is don't-care while dn_valid_o=0.
- Payload gating: payload registers load only on an accepting transfer into that slot, which allows clock gating.
- Upstream protocol: up_payload_i must be stable while up_valid_i=1 & !up_ready_o. The block does not check this; an assertion does.
- Mid-operation reset: asynchronous clear of all valids and payloads regardless of state. No entry survives.
- Width rule: the payload passes through bit-exact; the block does no arithmetic on it. occupancy_o saturates by construction and never shows 3.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum logic [1:0] pr_state_e {PR_EMPTY, PR_ONE, PR_TWO};
  - localparam OCC_W = 2.
  - The per-stage payload struct typedefs (ex_mem_payload_t, etc.) that callers pack into PAYLOAD_W.
- Sub-module: pr_slot, one valid+payload register with a load enable and clear. It is instantiated once (SKID_EN=0) or twice (SKID_EN=1) under a generate.

Test Plan:
- Reset then single push: rst_n low 3 cycles, release. Push payload 0x0000_1234 with dn_ready_i=1 -> dn_valid_o=1 with payload 0x1234 one cycle later, occupancy_o=1, then 0 after consumption.
- Stall fill: dn_ready_i=0, push A=0xA, B=0xB on consecutive cycles -> occupancy 1 then 2, up_ready_o=0 the cycle after B. Hold 5 cycles with payload stable at 0xA. Raise dn_ready_i -> 0xA then 0xB emitted in order.
- Streaming: dn_ready_i=1, push 100 back-to-back incrementing values -> one output per cycle, 1-cycle latency, up_ready_o constantly 1, no drops.
- Flush collision: state TWO (0xC, 0xD) plus flush_i=1 with up_valid_i=1 payload 0xE -> next cycle dn_valid_o=0, occupancy 0. 0xE never appears on dn_payload_o.
- Async reset mid-stream: assert rst_n low between edges while in TWO -> dn_valid_o=0 and dn_payload_o=RST_VAL immediately, without waiting for a clock edge.
- SKID_EN=0 variant: dn_ready_i=0 with main full -> up_ready_o=0 in the same cycle. dn_ready_i=1 -> up_ready_o=1 in the same cycle, and a simultaneous push/pop keeps occupancy 1.
